// File: rtl/sensor_conditioner.sv
// sensor_conditioner: conditions the two raw loop-detector inputs (roads A/B)
// into clean car-presence levels Sa/Sb plus one-cycle arrival pulses.
// Each channel has a 2-flop synchronizer, then a debounce/hold FSM.
// Optional stuck-sensor detection is built when SENSOR_STUCK_DET_EN is defined;
// without it fault_a/fault_b are constant 0.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no car, Sx=0, waiting for first synchronized high sample
// ARM     | Sx=0, counting consecutive high samples toward acceptance
// ACTIVE  | Sx=1, minimum hold running or expired and input high
// RELEASE | Sx=1, counting consecutive low samples toward release
// FAULT   | Sx=0, fault_x=1, sensor stuck high; waits for a clean low run
module sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int HOLD_CYCLES     = 8,
  parameter int STUCK_LIMIT     = 1024,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw_a,
  input  logic raw_b,
  output logic Sa,
  output logic Sb,
  output logic sa_rise,
  output logic sb_rise,
  output logic fault_a,
  output logic fault_b
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARM     = 3'd1,
    ST_ACTIVE  = 3'd2,
    ST_RELEASE = 3'd3
`ifdef SENSOR_STUCK_DET_EN
    ,
    ST_FAULT   = 3'd4
`endif
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES);
`ifdef SENSOR_STUCK_DET_EN
  localparam logic [CNT_W-1:0] STUCK_LAST = CNT_W'(STUCK_LIMIT - 1);
`else
  // STUCK_LIMIT only matters when stuck detection is built in.
  logic unused_stuck_limit;
  assign unused_stuck_limit = ^STUCK_LIMIT;
`endif

  logic [1:0] raw_vec;
  logic [1:0] level_vec;
  logic [1:0] rise_vec;
  logic [1:0] fault_vec;

  assign raw_vec = {raw_b, raw_a};
  assign Sa      = level_vec[0];
  assign Sb      = level_vec[1];
  assign sa_rise = rise_vec[0];
  assign sb_rise = rise_vec[1];
  assign fault_a = fault_vec[0];
  assign fault_b = fault_vec[1];

  for (genvar ch = 0; ch < 2; ch++) begin : g_chan
    logic             sync_q1;
    logic             sync_x;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hold;
    logic             level;
    logic             rise;
    logic             fault;
`ifdef SENSOR_STUCK_DET_EN
    logic [CNT_W-1:0] stuck;
`endif

    // bring the asynchronous detector input into the clk domain
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        sync_q1 <= 1'b0;
        sync_x  <= 1'b0;
      end else begin
        sync_q1 <= raw_vec[ch];
        sync_x  <= sync_q1;
      end
    end

    // debounce / hold FSM with registered presence, pulse and fault outputs
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state <= ST_IDLE;
        cnt   <= '0;
        hold  <= '0;
        level <= 1'b0;
        rise  <= 1'b0;
`ifdef SENSOR_STUCK_DET_EN
        stuck <= '0;
        fault <= 1'b0;
`endif
      end else begin
        rise <= 1'b0;
        case (state)
          ST_IDLE: begin
            level <= 1'b0;
            cnt   <= '0;
`ifdef SENSOR_STUCK_DET_EN
            stuck <= '0;
`endif
            if (sync_x) begin
              if (DB_LAST == '0) begin
                state <= ST_ACTIVE;
                level <= 1'b1;
                rise  <= 1'b1;
                hold  <= '0;
              end else begin
                state <= ST_ARM;
                cnt   <= CNT_ONE;
              end
            end
          end
          ST_ARM: begin
            if (!sync_x) begin
              state <= ST_IDLE;
              cnt   <= '0;
            end else if (cnt == DB_LAST) begin
              state <= ST_ACTIVE;
              level <= 1'b1;
              rise  <= 1'b1;
              hold  <= '0;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
          ST_ACTIVE: begin
            // input is ignored until the minimum hold has elapsed
            if (hold != HOLD_MAX) begin
              hold <= hold + CNT_ONE;
            end else if (!sync_x) begin
              if (DB_LAST == '0) begin
                state <= ST_IDLE;
                level <= 1'b0;
              end else begin
                state <= ST_RELEASE;
                cnt   <= CNT_ONE;
              end
            end
          end
          ST_RELEASE: begin
            // a return to high keeps the car present; hold stays saturated
            if (sync_x) begin
              state <= ST_ACTIVE;
              cnt   <= '0;
            end else if (cnt == DB_LAST) begin
              state <= ST_IDLE;
              level <= 1'b0;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
`ifdef SENSOR_STUCK_DET_EN
          ST_FAULT: begin
            level <= 1'b0;
            if (sync_x) begin
              cnt <= '0;
            end else if (cnt == DB_LAST) begin
              state <= ST_IDLE;
              fault <= 1'b0;
              cnt   <= '0;
            end else begin
              cnt <= cnt + CNT_ONE;
            end
          end
`endif
          default: begin
            state <= ST_IDLE;
            level <= 1'b0;
            cnt   <= '0;
            hold  <= '0;
`ifdef SENSOR_STUCK_DET_EN
            fault <= 1'b0;
            stuck <= '0;
`endif
          end
        endcase
`ifdef SENSOR_STUCK_DET_EN
        // a dead-high sensor overrides the normal presence path
        if (state == ST_ACTIVE || state == ST_RELEASE) begin
          if (!sync_x) begin
            stuck <= '0;
          end else if (stuck == STUCK_LAST) begin
            state <= ST_FAULT;
            level <= 1'b0;
            fault <= 1'b1;
            cnt   <= '0;
            stuck <= '0;
          end else begin
            stuck <= stuck + CNT_ONE;
          end
        end
`endif
      end
    end

`ifndef SENSOR_STUCK_DET_EN
    assign fault = 1'b0;
`endif

    assign level_vec[ch] = level;
    assign rise_vec[ch]  = rise;
    assign fault_vec[ch] = fault;
  end

endmodule

// File: tb/tb_sensor_conditioner.sv
// Testbench for sensor_conditioner: directed scenarios plus random run-length
// stimulus, all checked every cycle against a run-length reference model.
module tb_sensor_conditioner;

  localparam int DB    = 4;
  localparam int HOLD  = 8;
  localparam int STUCK = 20;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic raw_a = 1'b0;
  logic raw_b = 1'b0;
  logic Sa, Sb, sa_rise, sb_rise, fault_a, fault_b;

  int n_tests = 0;
  int n_fail  = 0;
  int edge_n  = 0;

  sensor_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .HOLD_CYCLES(HOLD),
    .STUCK_LIMIT(STUCK),
    .CNT_W(16)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .raw_a(raw_a),
    .raw_b(raw_b),
    .Sa(Sa),
    .Sb(Sb),
    .sa_rise(sa_rise),
    .sb_rise(sb_rise),
    .fault_a(fault_a),
    .fault_b(fault_b)
  );

  always #5 clk = ~clk;

  // reference model: per channel, synchronizer delay line plus run lengths
  int m_sy1[2], m_sy2[2];
  int m_out[2], m_rise[2], m_fault[2];
  int m_run1[2], m_run0[2], m_age[2], m_stuck[2];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, obs, exp, edge_n);
    end
  endtask

  task automatic model_reset();
    for (int ch = 0; ch < 2; ch++) begin
      m_sy1[ch] = 0; m_sy2[ch] = 0;
      m_out[ch] = 0; m_rise[ch] = 0; m_fault[ch] = 0;
      m_run1[ch] = 0; m_run0[ch] = 0; m_age[ch] = 0; m_stuck[ch] = 0;
    end
  endtask

  task automatic model_edge(input logic ra, input logic rb);
    int s;
    bit tripped;
    for (int ch = 0; ch < 2; ch++) begin
      s = m_sy2[ch];
      m_sy2[ch] = m_sy1[ch];
      m_sy1[ch] = (ch == 0) ? int'(ra) : int'(rb);
      m_rise[ch] = 0;
      tripped = 1'b0;
      if (m_fault[ch] != 0) begin
        m_run0[ch] = (s != 0) ? 0 : m_run0[ch] + 1;
        if (m_run0[ch] == DB) begin
          m_fault[ch] = 0; m_run0[ch] = 0; m_run1[ch] = 0;
        end
      end else if (m_out[ch] == 0) begin
        m_run1[ch] = (s != 0) ? m_run1[ch] + 1 : 0;
        if (m_run1[ch] == DB) begin
          m_out[ch] = 1; m_rise[ch] = 1; m_age[ch] = 0;
          m_run0[ch] = 0; m_run1[ch] = 0; m_stuck[ch] = 0;
        end
      end else begin
`ifdef SENSOR_STUCK_DET_EN
        if (s != 0) begin
          m_stuck[ch]++;
          if (m_stuck[ch] == STUCK) begin
            m_out[ch] = 0; m_fault[ch] = 1; m_run0[ch] = 0; tripped = 1'b1;
          end
        end else begin
          m_stuck[ch] = 0;
        end
`endif
        if (!tripped) begin
          if (m_age[ch] >= HOLD) begin
            m_run0[ch] = (s != 0) ? 0 : m_run0[ch] + 1;
            if (m_run0[ch] == DB) begin
              m_out[ch] = 0; m_run0[ch] = 0; m_run1[ch] = 0;
            end
          end else begin
            m_age[ch]++;
          end
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge(raw_a, raw_b);
    edge_n++;
    @(negedge clk);
    check_val("Sa", Sa, m_out[0]);
    check_val("Sb", Sb, m_out[1]);
    check_val("sa_rise", sa_rise, m_rise[0]);
    check_val("sb_rise", sb_rise, m_rise[1]);
    check_val("fault_a", fault_a, m_fault[0]);
    check_val("fault_b", fault_b, m_fault[1]);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_Sa"}, Sa, 0);
    check_val({tag, "_Sb"}, Sb, 0);
    check_val({tag, "_sa_rise"}, sa_rise, 0);
    check_val({tag, "_sb_rise"}, sb_rise, 0);
    check_val({tag, "_fault_a"}, fault_a, 0);
    check_val({tag, "_fault_b"}, fault_b, 0);
  endtask

  initial begin
    int highs, rises, ka, kb, found, seen;
    int rem[2];
    logic lvl[2];

    model_reset();
    @(negedge clk);
    check_all_zero("reset");
    reset_n = 1'b1;
    edge_n = 0;

    // clean arrival on A with raw_a high before edge 10
    repeat (9) step();
    raw_a = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (edge_n == 14) check_val("arrive_early", Sa, 0);
      if (edge_n == 15) begin
        check_val("arrive_sa", Sa, 1);
        check_val("arrive_rise", sa_rise, 1);
        check_val("arrive_sb", Sb, 0);
      end
      if (edge_n == 16) check_val("arrive_rise_drop", sa_rise, 0);
    end
    raw_a = 1'b0;
    repeat (20) step();

    // glitch on B shorter than the debounce window
    seen = 0;
    raw_b = 1'b1;
    for (int i = 0; i < 13; i++) begin
      if (i == 3) raw_b = 1'b0;
      step();
      seen = seen | int'(Sb) | int'(sb_rise);
    end
    check_val("glitch_b", seen, 0);

    // hold: 6 high then low -> 12 cycles present, one rise
    highs = 0; rises = 0;
    raw_a = 1'b1;
    for (int i = 0; i < 31; i++) begin
      if (i == 6) raw_a = 1'b0;
      step();
      highs += int'(Sa);
      rises += int'(sa_rise);
    end
    check_val("hold_highs", highs, HOLD + DB);
    check_val("hold_rises", rises, 1);

    // hold with a 2-cycle re-pulse landing in the release window
    highs = 0; rises = 0;
    for (int i = 0; i < 36; i++) begin
      raw_a = (i < 6 || i == 14 || i == 15) ? 1'b1 : 1'b0;
      step();
      highs += int'(Sa);
      rises += int'(sa_rise);
    end
    check_val("repulse_highs", highs, 16);
    check_val("repulse_rises", rises, 1);

    // simultaneous arrival on both roads
    ka = -1; kb = -1;
    raw_a = 1'b1; raw_b = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      if (sa_rise && ka < 0) ka = i;
      if (sb_rise && kb < 0) kb = i;
    end
    check_val("simul_a_edge", ka, 1 + DB);
    check_val("simul_b_edge", kb, 1 + DB);
    raw_a = 1'b0; raw_b = 1'b0;
    repeat (25) step();

    // reset while A is in ARM with cnt=2 and B is present
    raw_b = 1'b1;
    repeat (10) step();
    raw_a = 1'b1;
    repeat (4) step();
    check_val("pre_rst_Sb", Sb, 1);
    reset_n = 1'b0;
    #1;
    check_all_zero("rst_mid");
    model_reset();
    @(negedge clk);
    check_all_zero("rst_hold");
    reset_n = 1'b1;
    found = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (Sa && found < 0) found = k;
    end
    check_val("rst_rearm_sa", found, 2 + DB);

    // B held high for a long time
    raw_a = 1'b0;
    repeat (40) step();
`ifdef SENSOR_STUCK_DET_EN
    check_val("stuck_Sb", Sb, 0);
    check_val("stuck_fault", fault_b, 1);
    raw_b = 1'b0;
    found = -1;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (!fault_b && found < 0) found = k;
    end
    check_val("stuck_exit", found, 2 + DB);
`else
    check_val("stuck_Sb", Sb, 1);
    check_val("stuck_fault", fault_b, 0);
    raw_b = 1'b0;
    repeat (20) step();
`endif

    // random run-length stimulus, short glitches mixed with long holds
    rem[0] = 0; rem[1] = 0;
    lvl[0] = 1'b0; lvl[1] = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      for (int ch = 0; ch < 2; ch++) begin
        if (rem[ch] == 0) begin
          lvl[ch] = ~lvl[ch];
          rem[ch] = int'($urandom_range(1, ($urandom_range(0, 3) == 0) ? 30 : 8));
        end
        rem[ch]--;
      end
      raw_a = lvl[0];
      raw_b = lvl[1];
      if (c == 700) begin
        reset_n = 1'b0;
        #1;
        check_all_zero("rand_rst");
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sensor_conditioner.md
Name: sensor_conditioner

Overview:
- Front-end stage feeding the two-road traffic light controller's Sa/Sb car-presence inputs.
- Synchronizes the two raw, asynchronous, bouncy loop-detector inputs to clk.
- Debounces each channel and enforces a minimum presence-hold time.
- Produces clean registered presence levels plus one-cycle arrival pulses. Two identical, independent channel instances (A, B) live inside one module.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive identical synchronized samples required to accept a level change; legal range 1..2^CNT_W-1.
- HOLD_CYCLES, 8: minimum cycles Sx stays high after assertion, regardless of input; 0 disables the hold.
- STUCK_LIMIT, 1024: continuous-high cycles before a channel is declared stuck. Used only with the optional feature.
- CNT_W, 16: width of every internal counter. It must hold max(DEBOUNCE_CYCLES, HOLD_CYCLES, STUCK_LIMIT).

Ports:
- clk  input  1  clock
- reset_n  input  1  asynchronous, active-low reset
- raw_a  input  1  raw road-A detector, asynchronous to clk
- raw_b  input  1  raw road-B detector, asynchronous to clk
- Sa  output  1  conditioned road-A presence (registered)
- Sb  output  1  conditioned road-B presence (registered)
- sa_rise  output  1  one-cycle pulse coincident with the first cycle of Sa high
- sb_rise  output  1  one-cycle pulse coincident with the first cycle of Sb high
- fault_a  output  1  road-A stuck-sensor flag (registered)
- fault_b  output  1  road-B stuck-sensor flag (registered)

Behaviour:
- Reset: clk and reset_n as decided; reset_n is asynchronous and active-low.
  - All outputs go to 0 and both synchronizer flops clear to 0.
  - Both channel FSMs go to IDLE and all counters clear to 0.
  - Reset asserted mid-operation aborts everything immediately, with no pulse emitted.
- Synchronizer: two flops per channel; sync_x is the second flop. The filter uses only sync_x.
- Channel FSM, evaluated on every rising clk edge.
  - IDLE, Sx=0: sync_x=1 -> ARM with cnt=1.
  - ARM, Sx=0: sync_x=0 -> IDLE with cnt=0. sync_x=1 and cnt==DEBOUNCE_CYCLES-1 -> ACTIVE, with Sx=1, rise_x=1 for this cycle, and hold=0. Otherwise cnt++.
    - DEBOUNCE_CYCLES=1: IDLE goes directly to ACTIVE on the first sync_x=1 sample.
  - ACTIVE, Sx=1: hold counts up, saturating at HOLD_CYCLES. Once hold==HOLD_CYCLES and sync_x=0 -> RELEASE with cnt=1. While hold<HOLD_CYCLES, input is ignored.
  - RELEASE, Sx=1: sync_x=1 -> ACTIVE with hold left saturated, so no new rise pulse and no new hold. sync_x=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE with Sx=0. Otherwise cnt++.
    - DEBOUNCE_CYCLES=1: ACTIVE goes directly to IDLE.
  - Illegal state encoding -> IDLE.
- Latency:
  - raw_x rises before edge N and stays high -> Sx=1 and rise_x=1 after edge N+1+DEBOUNCE_CYCLES.
  - Release latency is the same once the hold has expired.
- rise_x is high for exactly one cycle per IDLE->ACTIVE transition and never otherwise.
- Glitches: a pulse or gap shorter than DEBOUNCE_CYCLES synchronized samples produces no output change.
- Channel independence: A and B are fully independent; simultaneous events on both are handled in the same cycle.

Optional Feature:
- Macro: SENSOR_STUCK_DET_EN.
- Defined: each channel has a stuck counter.
  - The counter increments every cycle that sync_x=1 while in ACTIVE/RELEASE, and clears on any sync_x=0 sample.
  - Reaching STUCK_LIMIT -> FAULT state: Sx forced to 0 next cycle and fault_x=1. This releases a controller parked waiting on a dead-high sensor.
  - FAULT exits to IDLE after DEBOUNCE_CYCLES consecutive sync_x=0 samples; fault_x clears in the same cycle.
  - While in FAULT, sync_x=1 only resets that exit count.
- Not defined: no stuck counter, no FAULT state, and fault_a/fault_b are tied to constant 0.

Test Plan:
- Clean arrival, defaults: raw_a held high from edge 10 -> Sa=1 and sa_rise=1 after edge 15; sa_rise=0 after edge 16; Sb stays 0.
- Glitch rejection: raw_b pulses high for 3 cycles, then low -> Sb and sb_rise stay 0 throughout.
- Hold time: raw_a high for 6 cycles (reaches ACTIVE), then low -> Sa high for 8 cycles of hold plus 4 cycles of release debounce, then 0. A raw_a re-pulse of 2 cycles during RELEASE -> Sa stays 1 and no second sa_rise.
- Simultaneous channels: raw_a and raw_b rise in the same cycle -> Sa/Sb and sa_rise/sb_rise assert on the same edge.
- Reset mid-operation: reset_n pulsed low while channel A is in ARM with cnt=2 -> all outputs 0 immediately. With raw_a still high after release, Sa asserts a full 2+4 cycles later.
- Stuck sensor (SENSOR_STUCK_DET_EN, STUCK_LIMIT=20): raw_b held high -> Sb=1, then Sb=0 and fault_b=1 about 20 cycles after assertion. raw_b then low -> fault_b=0 after 2+4 cycles. Without the macro -> Sb stays 1 and fault_b stays 0.
